// File: rtl/tortoise_pkg.sv
// tortoise_pkg: shared front-end sizing and the fetch entry carried from fetch to decode.
package tortoise_pkg;
   localparam int IFQ_DEPTH       = 8;
   localparam int INSTR_PER_FETCH = 2;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mp.sv
// fetch_queue_mp: multi-port instruction fetch queue with lane compaction, partial pop and flush.
module fetch_queue_mp #(
   parameter int DEPTH  = tortoise_pkg::IFQ_DEPTH,
   parameter int PUSH_W = tortoise_pkg::INSTR_PER_FETCH,
   parameter int POP_W  = 2,
   parameter int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    flush_i,
   input  logic [PUSH_W-1:0]                       push_valid_i,
   input  tortoise_pkg::fetch_entry_t [PUSH_W-1:0] push_data_i,
   output logic                                    push_ready_o,
   output logic [POP_W-1:0]                        pop_valid_o,
   output tortoise_pkg::fetch_entry_t [POP_W-1:0]  pop_data_o,
   input  logic [$clog2(POP_W+1)-1:0]              pop_cnt_i,
   output logic [CNT_W-1:0]                        count_o,
   output logic                                    full_o,
   output logic                                    empty_o
);
   localparam int PW = $clog2(DEPTH);
   tortoise_pkg::fetch_entry_t mem [DEPTH];
   logic [PW-1:0]    head, tail;
   logic [CNT_W-1:0] count, p, avail, c;
   logic [CNT_W-1:0] ofs [PUSH_W];
   logic             do_push;
   // each valid lane lands at tail plus the number of valid lanes below it
   always_comb begin
      p = '0;
      for (int i = 0; i < PUSH_W; i++) begin
         ofs[i] = p;
         p = p + CNT_W'(push_valid_i[i]);
      end
   end
   assign push_ready_o = count <= CNT_W'(DEPTH - PUSH_W);
   assign do_push      = push_ready_o && |push_valid_i;
   assign avail        = (count > CNT_W'(POP_W)) ? CNT_W'(POP_W) : count;
   assign c            = (CNT_W'(pop_cnt_i) > avail) ? avail : CNT_W'(pop_cnt_i);
   assign count_o      = count;
   assign full_o       = count == CNT_W'(DEPTH);
   assign empty_o      = count == '0;
   for (genvar k = 0; k < POP_W; k++) begin : g_pop
      assign pop_valid_o[k] = count > CNT_W'(k);
      assign pop_data_o[k]  = mem[head + PW'(k)];
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(c);
         tail  <= do_push ? tail + PW'(p) : tail;
         count <= count + (do_push ? p : '0) - c;
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i && !rst_i)
         for (int i = 0; i < PUSH_W; i++)
            if (push_valid_i[i]) mem[tail + PW'(ofs[i])] <= push_data_i[i];
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i) begin
         assert (count <= CNT_W'(DEPTH));
         assert (CNT_W'(pop_cnt_i) <= avail);
         for (int i = 0; i < PUSH_W; i++)
            if (do_push) assert (push_data_i[i].valid == push_valid_i[i]);
      end
   end
endmodule

// File: tb/tb_fetch_queue_mp.sv
// tb_fetch_queue_mp: directed and randomised traffic against a FIFO scoreboard of fetch entries.
module tb_fetch_queue_mp;
   import tortoise_pkg::*;
   logic                    clk_i = 0, rst_i = 1, flush_i = 0;
   logic [1:0]              push_valid_i = 0, pop_cnt_i = 0;
   fetch_entry_t [1:0]      push_data_i = '0;
   logic                    push_ready_o, full_o, empty_o;
   logic [1:0]              pop_valid_o;
   fetch_entry_t [1:0]      pop_data_o;
   logic [3:0]              count_o;
   fetch_entry_t            sb [$];
   int                      checks = 0, failures = 0, pcn = 32'h1000;

   fetch_queue_mp dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
      .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o), .pop_cnt_i(pop_cnt_i),
      .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic post();
      int n = sb.size();
      chk("count", 128'(count_o), 128'(n));
      chk("empty", 128'(empty_o), 128'(n == 0));
      chk("full", 128'(full_o), 128'(n == 8));
      chk("ready", 128'(push_ready_o), 128'(n <= 6));
      chk("pop_valid", 128'(pop_valid_o), 128'({n > 1, n > 0}));
      for (int k = 0; k < 2 && k < n; k++) chk("peek", 128'(pop_data_o[k]), 128'(sb[k]));
   endtask

   task automatic cyc(input logic [1:0] pv, input int pops, input bit fl);
      fetch_entry_t d [2];
      bit rdy;
      for (int i = 0; i < 2; i++) begin
         d[i].valid = pv[i];
         d[i].pc    = pcn;
         d[i].instr = $urandom;
         pcn += 4;
         push_data_i[i] = d[i];
      end
      push_valid_i = pv;
      pop_cnt_i    = 2'(pops);
      flush_i      = fl;
      rdy = sb.size() <= 6;
      chk("ready_pre", 128'(push_ready_o), 128'(rdy));
      if (fl) sb.delete();
      else begin
         for (int k = 0; k < pops; k++) chk("pop_data", 128'(pop_data_o[k]), 128'(sb.pop_front()));
         if (rdy) for (int i = 0; i < 2; i++) if (pv[i]) sb.push_back(d[i]);
      end
      @(posedge clk_i); #1;
      push_valid_i = 0; pop_cnt_i = 0; flush_i = 0;
      post();
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb.size() > 0; t++) cyc(2'b00, sb.size() > 1 ? 2 : 1, 0);
      chk("drained", 128'(count_o), 128'(0));
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      post();
      rst_i = 0;
      @(posedge clk_i); #1;
      post();
      // full group, then single-lane groups with compaction
      cyc(2'b11, 0, 0);
      cyc(2'b00, 2, 0);
      cyc(2'b01, 0, 0);
      cyc(2'b10, 0, 0);
      cyc(2'b01, 1, 0);
      drain();
      // fill to full, then offer a group that must be dropped
      repeat (4) cyc(2'b11, 0, 0);
      cyc(2'b11, 0, 0);
      drain();
      // count 7: push rejected while popping 2; count 6: push+pop holds
      repeat (3) cyc(2'b11, 0, 0);
      cyc(2'b01, 0, 0);
      cyc(2'b11, 2, 0);
      cyc(2'b01, 0, 0);
      cyc(2'b11, 2, 0);
      drain();
      // steady traffic across the wrap point with mixed group sizes
      for (int g = 0; g < 20; g++) cyc(2'($urandom_range(1, 3)), sb.size() > 1 ? 2 : sb.size(), 0);
      drain();
      // flush with push and pop in the same cycle
      cyc(2'b11, 0, 0);
      cyc(2'b11, 0, 0);
      cyc(2'b01, 0, 0);
      cyc(2'b11, 2, 1);
      cyc(2'b11, 0, 0);
      cyc(2'b00, 2, 0);
      // asynchronous reset mid-fill
      cyc(2'b11, 0, 0);
      cyc(2'b11, 0, 0);
      #3 rst_i = 1;
      #1;
      sb.delete();
      chk("async_count", 128'(count_o), 128'(0));
      chk("async_empty", 128'(empty_o), 128'(1));
      chk("async_valid", 128'(pop_valid_o), 128'(0));
      @(posedge clk_i); #1;
      rst_i = 0;
      post();
      cyc(2'b10, 0, 0);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
